// File: rtl/carregador_instrucoes_pkg.sv
// rtl/carregador_instrucoes_pkg.sv - shared states and constants for the program loader
package carregador_instrucoes_pkg;

    localparam int LEN_WIDTH         = 16;
    localparam int BYTES_POR_PALAVRA = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERRO   = 3'd6
    } estado_t;

endpackage

// File: rtl/carregador_instrucoes_montador_palavra.sv
// rtl/carregador_instrucoes_montador_palavra.sv - big-endian byte-to-word shift register
module montador_palavra
    import carregador_instrucoes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] cnt;

    // full flags the shift that completes the word, so the FSM can leave DATA on that edge
    assign full = shift && (cnt == 2'(BYTES_POR_PALAVRA - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            word <= 32'd0;
        end else if (clear) begin
            cnt  <= 2'd0;
            word <= 32'd0;
        end else if (shift) begin
            cnt  <= cnt + 2'd1;
            word <= {word[23:0], byte_in};
        end
    end

endmodule

// File: rtl/carregador_instrucoes.sv
// rtl/carregador_instrucoes.sv - stream-fed instruction-memory program loader
module carregador_instrucoes
    import carregador_instrucoes_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        erro
);

    localparam logic [LEN_WIDTH:0] PROFUNDIDADE = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    estado_t                estado, estado_prox;
    logic [LEN_WIDTH-1:0]   n_reg, n_prox, n_lido;
    logic [ADDR_WIDTH:0]    word_index, wi_prox;
    logic                   aceita, limpa, desloca, cheio;
    logic [31:0]            palavra;

    assign in_ready = (estado == LEN_HI) || (estado == LEN_LO) || (estado == DATA);
    assign busy     = in_ready || (estado == WRITE);
    assign cpu_hold = busy;
    assign done     = (estado == DONE);
    assign erro     = (estado == ERRO);
    assign mem_we   = (estado == WRITE);
    // address and data are held at zero outside the write cycle
    assign mem_addr  = mem_we ? BASE_ADDR + (32'(word_index) << 2) : 32'd0;
    assign mem_wdata = mem_we ? palavra : 32'd0;

    assign aceita = in_valid && in_ready;
    assign n_lido = {n_reg[LEN_WIDTH-1:8], in_data};

    montador_palavra u_montador (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (limpa),
        .shift   (desloca),
        .byte_in (in_data),
        .word    (palavra),
        .full    (cheio)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= IDLE;
            n_reg      <= '0;
            word_index <= '0;
        end else begin
            estado     <= estado_prox;
            n_reg      <= n_prox;
            word_index <= wi_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        n_prox      = n_reg;
        wi_prox     = word_index;
        limpa       = 1'b0;
        desloca     = 1'b0;
        case (estado)
            IDLE, DONE, ERRO: begin
                if (start) begin
                    estado_prox = LEN_HI;
                    wi_prox     = '0;
                    limpa       = 1'b1;
                end
            end
            LEN_HI: begin
                if (aceita) begin
                    n_prox      = {in_data, n_reg[7:0]};
                    estado_prox = LEN_LO;
                end
            end
            LEN_LO: begin
                if (aceita) begin
                    n_prox = n_lido;
                    if (n_lido == '0)
                        estado_prox = DONE;
                    else if ({1'b0, n_lido} > PROFUNDIDADE)
                        estado_prox = ERRO;
                    else
                        estado_prox = DATA;
                end
            end
            DATA: begin
                if (aceita) begin
                    desloca = 1'b1;
                    if (cheio)
                        estado_prox = WRITE;
                end
            end
            WRITE: begin
                wi_prox = word_index + {{ADDR_WIDTH{1'b0}}, 1'b1};
                if (32'(word_index) + 32'd1 == 32'(n_reg))
                    estado_prox = DONE;
                else
                    estado_prox = DATA;
            end
            default: estado_prox = IDLE;
        endcase
    end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb/tb_carregador_instrucoes.sv - self-checking bench for the program loader
module tb_carregador_instrucoes;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_hold, busy, done, erro;
    logic [31:0] mem_addr, mem_wdata;

    carregador_instrucoes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        int          mode;
        int          dsrc;
        logic        exp_done;
        logic        exp_erro;
        int          exp_writes;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          ciclo = 0;
    logic        we_ant = 1'b0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] memoria[256];
    logic [31:0] fixed_a[2];
    logic [31:0] fixed_b[1];
    vec_t        tab[8];

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    always @(posedge clk) ciclo++;

    always @(negedge clk) begin
        if (rst_n) begin
            check("hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
            check("done_erro_excl", {31'd0, done && erro}, 32'd0);
            if (mem_we) begin
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_wdata);
                obs_cyc.push_back(ciclo);
                memoria[mem_addr[9:2]] = mem_wdata;
                check("we_ready_low", {31'd0, in_ready}, 32'd0);
                check("we_single_cycle", {31'd0, we_ant}, 32'd0);
                check("addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
            end
            we_ant = mem_we;
        end else begin
            we_ant = 1'b0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        check("busy_hold_loading", {30'd0, busy, cpu_hold}, 32'd3);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_load(input vec_t v);
        logic [7:0]  bytes[$];
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] w;
        int          g = 0;
        bool_legal: begin end
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        bytes.push_back(v.n[15:8]);
        bytes.push_back(v.n[7:0]);
        if (v.n != 0 && v.n <= 256) begin
            for (int i = 0; i < int'(v.n); i++) begin
                case (v.dsrc)
                    0:       w = $urandom;
                    1:       w = 32'(i);
                    2:       w = fixed_a[i];
                    default: w = fixed_b[i];
                endcase
                exp_addr.push_back(32'(4 * i));
                exp_data.push_back(w);
                bytes.push_back(w[31:24]);
                bytes.push_back(w[23:16]);
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
            end
        end
        pulse_start();
        check("start_clears_flags", {30'd0, done, erro}, 32'd0);
        check("start_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < bytes.size(); k++) begin
            if (v.mode == 1 && k > 0) gap(2);
            else if (v.mode == 2) gap($urandom_range(0, 2));
            send_byte(bytes[k]);
        end
        in_valid = 1'b0;
        while (!(done || erro) && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g >= 10) check("finish_timeout", 32'd0, 32'd1);
        check("final_done", {31'd0, done}, {31'd0, v.exp_done});
        check("final_erro", {31'd0, erro}, {31'd0, v.exp_erro});
        check("final_idle_ready", {29'd0, in_ready, busy, cpu_hold}, 32'd0);
        check("write_count", obs_addr.size(), v.exp_writes);
        check("model_count", exp_addr.size(), obs_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check("write_addr", obs_addr[i], exp_addr[i]);
            check("write_data", obs_data[i], exp_data[i]);
        end
        if (v.mode == 0) begin
            for (int i = 1; i < obs_cyc.size(); i++)
                check("word_period", obs_cyc[i] - obs_cyc[i-1], 5);
        end
        if (v.dsrc == 1 && v.n == 256) begin
            for (int i = 0; i < 256; i++)
                check("memoria_readback", memoria[i], 32'(i));
        end
    endtask

    initial begin
        fixed_a[0] = 32'h8C09_0000;
        fixed_a[1] = 32'hAC09_0004;
        fixed_b[0] = 32'h2008_0005;
        tab[0] = '{16'd0,     0, 0, 1'b1, 1'b0, 0};
        tab[1] = '{16'd2,     0, 2, 1'b1, 1'b0, 2};
        tab[2] = '{16'd2,     1, 2, 1'b1, 1'b0, 2};
        tab[3] = '{16'd257,   0, 0, 1'b0, 1'b1, 0};
        tab[4] = '{16'd3,     2, 0, 1'b1, 1'b0, 3};
        tab[5] = '{16'hFFFF,  2, 0, 1'b0, 1'b1, 0};
        tab[6] = '{16'd1,     2, 0, 1'b1, 1'b0, 1};
        tab[7] = '{16'd256,   0, 1, 1'b1, 1'b0, 256};

        repeat (2) @(negedge clk);
        check("reset_flags", {26'd0, in_ready, mem_we, cpu_hold, busy, done, erro}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_flags", {26'd0, in_ready, mem_we, cpu_hold, busy, done, erro}, 32'd0);

        // reset in the middle of a word: nothing may be written
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h08);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_flags", {26'd0, in_ready, mem_we, cpu_hold, busy, done, erro}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("aborted_no_write", obs_addr.size(), 0);
        do_load('{16'd1, 0, 3, 1'b1, 1'b0, 1});

        // start during LEN_LO must be ignored
        obs_addr.delete();
        pulse_start();
        send_byte(8'h00);
        in_valid = 1'b0;
        pulse_start();
        check("start_in_len_lo", {30'd0, in_ready, busy}, 32'd3);
        send_byte(8'h00);
        in_valid = 1'b0;
        check("zero_len_done", {30'd0, done, busy}, 32'd2);
        check("zero_len_nowrite", obs_addr.size(), 0);

        for (int t = 0; t < 8; t++) do_load(tab[t]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/carregador_instrucoes.md
Name: carregador_instrucoes

Overview:
Program loader that writes the instruction memory, the write-side counterpart of the processor's combinational instruction-memory read port.
- Accepts a byte stream over a valid/ready handshake.
- The stream is a 16-bit word count N followed by 4N bytes.
- Assembles big-endian 32-bit words and issues one-cycle write strobes with word-aligned byte addresses.
- Holds the CPU stalled while loading, then reports done or error.

Parameters:
ADDR_WIDTH, 8, word-index width; memory depth = 2**ADDR_WIDTH words (256 by default).
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
clk  input  1  system clock, all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERRO.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready at the rising edge.
mem_we  output  1  instruction-memory write enable, one cycle per word.
mem_addr  output  32  byte address of the write, always word-aligned (bits [1:0] = 0).
mem_wdata  output  32  word to write.
cpu_hold  output  1  stalls the processor/PC while loading.
busy  output  1  load in progress.
done  output  1  load completed successfully (level).
erro  output  1  header rejected (level).

Behaviour:
- Reset values:
  - All outputs are 0, including cpu_hold, in_ready, mem_we, mem_addr and mem_wdata.
  - FSM goes to IDLE; word counter, byte counter and assembly register are cleared.
- Reset mid-load:
  - FSM returns to IDLE immediately and the partially assembled word is discarded.
  - Words already written remain in memory.
- States and transitions:
  - IDLE: start -> LEN_HI.
  - LEN_HI: accepted byte becomes N[15:8] -> LEN_LO.
  - LEN_LO: accepted byte becomes N[7:0]. Then:
    - N == 0 -> DONE.
    - N > 2**ADDR_WIDTH -> ERRO.
    - otherwise -> DATA.
  - DATA: accepts bytes and shifts them into the assembly register, first byte into [31:24] (big-endian, MIPS order). On acceptance of the 4th byte -> WRITE.
  - WRITE: mem_we=1 for exactly this cycle, with mem_wdata = the assembled word and mem_addr = BASE_ADDR + 4*word_index. Then word_index increments:
    - word_index+1 == N -> DONE.
    - otherwise -> DATA.
  - DONE: done=1. start -> LEN_HI, clearing done, word_index and byte counter.
  - ERRO: erro=1; nothing is written. start -> LEN_HI, clearing erro.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- Output rules:
  - in_ready = 1 only in LEN_HI, LEN_LO and DATA; it is 0 in WRITE, so the 5th byte waits one cycle.
  - busy = cpu_hold = 1 in LEN_HI, LEN_LO, DATA and WRITE.
  - done and erro are mutually exclusive.
  - All outputs are registered or decoded from the state register only; no combinational path from in_valid to in_ready.
- Latency and throughput:
  - 4th byte accepted at edge k -> mem_we high in the cycle after edge k -> memory write at edge k+1.
  - Sustained throughput is 1 word per 5 cycles with in_valid held high.
- in_valid low stalls any state without side effects. in_data is ignored when in_valid is low.
- N == 2**ADDR_WIDTH is legal; the last address is BASE_ADDR + 4*(2**ADDR_WIDTH - 1).
- Counter widths:
  - word_index is ADDR_WIDTH+1 bits.
  - The address sum is 32-bit and wraps modulo 2**32; no wrap occurs when BASE_ADDR is aligned and the load is legal.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERRO);
  - the length-field width (16);
  - the bytes-per-word constant (4).
- One natural sub-module, montador_palavra: a byte-to-word shift register with a 2-bit byte counter and a full flag. It has clear and shift inputs, outputs the 32-bit word, and asserts full on the 4th byte.
- The FSM, address generation and counters stay in the top module.

Test Plan:
- Reset check: drive rst_n low mid-stream after 2 of 4 data bytes, then release, start, and send N=1 with bytes 20 08 00 05 -> single write with mem_wdata=32'h20080005 at mem_addr=0. No write results from the aborted bytes.
- Back-to-back stream: start, stream 00 02 then 8C 09 00 00 AC 09 00 04 with in_valid held high -> writes 32'h8C090000 at address 0 and 32'hAC090004 at address 4, each mem_we exactly 1 cycle. in_ready is 0 during each WRITE cycle; done=1 after the 2nd write.
- Stalled stream: same stream as above with in_valid toggled 1 cycle on, 2 cycles off -> identical writes and addresses. busy and cpu_hold stay 1 throughout.
- Zero-length header: start, header 00 00 -> DONE two accepted bytes later with no mem_we. A start pulse issued during LEN_LO is ignored.
- Oversized header: start, header 01 01 (N=257 > 256) -> erro=1, no write, in_ready=0. A new start clears erro and a legal load then succeeds.
- Full-depth load: N=256 with data word = index -> last write at mem_addr=32'h3FC. Memory model reads back memoria[i]==i for all i, and done=1.
